uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Oversampling UART receiver for the serial line driven by uart_tx (8N1, LSB first, idle high).
//  Sits at the line end of the serial link and recovers bytes with mid-bit sampling.
//  Rejects false start bits and flags framing errors.
//  Hands each byte to the consumer over a valid/ready handshake with a sticky overrun flag.
// PARAMETERS
//  OVERSAMPLE  16  baud_tick cycles per bit; even, >= 4
//  DATA_BITS   8   data bits per frame (1..8)
// PORTS
//  baud_tick  in   1          clock; runs at OVERSAMPLE x baud rate; all logic on rising edge
//  reset      in   1          synchronous, active-high reset
//  rx_in      in   1          asynchronous serial line; idle = 1
//  rx_data    out  DATA_BITS  received byte; stable while rx_valid = 1
//  rx_valid   out  1          byte available; held until accepted
//  rx_ready   in   1          consumer accepts byte when rx_valid & rx_ready at a clock edge
//  frame_err  out  1          one-cycle pulse: stop bit sampled 0
//  overrun    out  1          sticky: a byte was dropped because rx_valid was still pending
//  busy       out  1          1 in any state other than IDLE
// BEHAVIOUR
//  Clock and reset
//  - One clock (baud_tick). Reset is synchronous and active-high.
//  - Reset takes priority over every other event, mid-frame included. It forces:
//    state=IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, counters=0,
//    synchroniser flops=1.
//  Input path and bit timing
//  - rx_in passes through a 2-flop synchroniser (rx_s). Only rx_s is used internally.
//  - cnt counts baud_tick cycles within the current bit period. bitn counts received data bits.
//  FSM (registered)
//  - IDLE: when rx_s==0, go to START with cnt=0.
//  - START: when cnt==OVERSAMPLE/2-1, sample rx_s.
//    * rx_s==1: glitch; return to IDLE with no output.
//    * rx_s==0: cnt=0, bitn=0, go to DATA.
//  - DATA: when cnt==OVERSAMPLE-1, sample rx_s into shift[bitn] (LSB first) and set cnt=0.
//    After DATA_BITS samples, go to STOP.
//  - STOP: when cnt==OVERSAMPLE-1, sample rx_s.
//    * rx_s==1: deliver the byte (see below), go to IDLE.
//    * rx_s==0: pulse frame_err for one cycle, discard the byte, go to BRK.
//  - BRK: wait for rx_s==1, then go to IDLE. This covers a break or stuck-low line;
//    no new start is detected until the line returns high.
//  Deliver (at the stop-sample edge; rx_valid/rx_data update on the next edge)
//  - If rx_valid==0, or rx_valid&rx_ready in the same cycle: load rx_data, rx_valid=1.
//  - Otherwise drop the new byte and set overrun=1. rx_data is unchanged.
//  Handshake
//  - rx_valid falls on the edge after rx_valid&rx_ready, unless a deliver happens in that
//    same cycle; then rx_valid stays 1 and rx_data takes the new byte.
//  - overrun clears only on an accept (rx_valid&rx_ready) or on reset.
//  - rx_ready has no effect while rx_valid==0.
//  Latency
//  - From the rx_in falling edge to rx_valid rising:
//    2 (sync) + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE + 1 cycles, +/-1 for edge phase.
//    This is 155 cycles at the defaults.
//  - Back-to-back frames with no idle time between them are received without loss.
//    The next start bit is detected from IDLE. STOP exits OVERSAMPLE/2 cycles before the
//    frame ends.
// TESTING
//  1 Reset, rx_in=1 for 200 cycles -> rx_valid=0, busy=0, frame_err never pulses.
//  2 Frame 0x9B (line bits 0,1,1,0,1,1,0,0,1,1), rx_ready=1 -> one rx_valid pulse,
//    rx_data=8'h9B, rising 155+/-1 cycles after the start edge.
//  3 Low glitch of 4 cycles on an idle line -> return to IDLE, no rx_valid, no frame_err.
//  4 Frame 0x55 with stop bit driven 0, then line held low 40 cycles -> frame_err pulses once.
//    rx_valid stays 0. busy stays 1 until the line goes high. The next 0xA5 frame is received
//    correctly.
//  5 rx_ready=0, frames 0x12 then 0x34 -> rx_data=0x12 held, overrun=1.
//    Assert rx_ready for one cycle -> rx_valid=0, overrun=0.
//  6 Assert reset in the middle of DATA of frame 0xF0, release reset, send 0x0F
//    -> no output for 0xF0; rx_data=0x0F.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampling 8N1 UART receiver: mid-bit sampling, false-start rejection,
// framing-error pulse and a valid/ready output with a sticky overrun flag.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on rx_s
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling DATA_BITS data bits at mid-bit, LSB first
// STOP  | sampling the stop bit at mid-bit
// BRK   | stop bit was low; waiting for the line to return high
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 baud_tick,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic                 sync1;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitn;
    logic [DATA_BITS-1:0] shift;
    logic                 cnt_done;
    logic                 accept;
    logic                 deliver;

    assign cnt_done = (cnt == '0);
    assign accept   = rx_valid & rx_ready;
    assign deliver  = (state == STOP) & cnt_done & rx_s;
    assign busy     = (state != IDLE);

    always_ff @(posedge baud_tick) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    // cnt is a down-counter: loaded with the distance to the next sample point,
    // the sample happens at terminal count zero.
    always_ff @(posedge baud_tick) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bitn      <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= CNT_HALF;
                    end
                end
                START: begin
                    if (cnt_done) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            cnt   <= CNT_FULL;
                            bitn  <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_done) begin
                        shift[bitn] <= rx_s;
                        cnt         <= CNT_FULL;
                        if (bitn == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bitn <= bitn + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_done) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A delivery in the same cycle as an accept replaces the byte without a gap.
    always_ff @(posedge baud_tick) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (accept) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            if (deliver) begin
                if (!rx_valid || accept) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: frame-level scoreboard of expected deliveries
// and framing errors, checked every cycle, plus directed literal checks.
module tb_uart_rx_oversampled;
    logic       baud_tick = 1'b0;
    logic       reset     = 1'b1;
    logic       rx_in     = 1'b1;
    logic       rx_ready  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_oversampled #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .baud_tick (baud_tick),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 baud_tick = ~baud_tick;

    int cyc = 0;
    always @(posedge baud_tick) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] b;
        logic       good;
    } ev_t;
    ev_t sched[$];

    int checks = 0;
    int passed = 0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       rdy_q   = 1'b1;
    logic       rst_q   = 1'b1;

    logic       prev_valid = 1'b0;
    int         rise_cnt   = 0;
    int         rise_cyc   = 0;
    int         ferr_cnt   = 0;
    logic [7:0] rise_data  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge baud_tick);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        step(16);
    endtask

    // A frame whose start edge is driven just after clock edge k ends its
    // stop-bit sample at edge k+155.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        ev_t e;
        e.at   = cyc + 155;
        e.b    = b;
        e.good = stop_bit;
        sched.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    // Advance the frame-level model across the clock edge just taken.
    task automatic model_edge();
        logic acc;
        logic was_valid;
        ev_t  e;
        if (rst_q) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
            sched.delete();
        end else begin
            was_valid = m_valid;
            acc       = m_valid && rdy_q;
            m_ferr    = 1'b0;
            if (acc) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            if (sched.size() > 0 && sched[0].at == cyc) begin
                e = sched.pop_front();
                if (e.good) begin
                    if (!was_valid || acc) begin
                        m_data  = e.b;
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_ferr = 1'b1;
                end
            end
        end
        rdy_q = rx_ready;
        rst_q = reset;
    endtask

    initial begin
        int k;
        fork
            forever begin
                @(negedge baud_tick);
                model_edge();
                check("per-cycle {valid,data,overrun,frame_err}",
                      {21'd0, rx_valid, rx_data, overrun, frame_err},
                      {21'd0, m_valid, m_data, m_ovr, m_ferr});
                if (rx_valid && !prev_valid) begin
                    rise_cnt++;
                    rise_cyc  = cyc;
                    rise_data = rx_data;
                end
                if (frame_err) ferr_cnt++;
                prev_valid = rx_valid;
            end
            begin
                step(3);
                reset = 1'b0;

                step(200);
                check("idle rx_valid", rx_valid, 0);
                check("idle busy", busy, 0);
                check("idle frame_err pulses", ferr_cnt, 0);

                rise_cnt = 0;
                k = cyc;
                send_frame(8'h9B, 1'b1);
                step(10);
                check("9B deliveries", rise_cnt, 1);
                check("9B data", rise_data, 8'h9B);
                check("9B latency within 155+/-1",
                      (rise_cyc - k >= 154 && rise_cyc - k <= 156), 1);

                rise_cnt = 0;
                ferr_cnt = 0;
                rx_in = 1'b0;
                step(4);
                rx_in = 1'b1;
                step(30);
                check("glitch busy", busy, 0);
                check("glitch deliveries", rise_cnt, 0);
                check("glitch frame_err pulses", ferr_cnt, 0);

                rise_cnt = 0;
                ferr_cnt = 0;
                send_frame(8'h55, 1'b0);
                step(40);
                check("break busy while low", busy, 1);
                check("break frame_err pulses", ferr_cnt, 1);
                check("break deliveries", rise_cnt, 0);
                rx_in = 1'b1;
                step(4);
                check("break busy after high", busy, 0);
                send_frame(8'hA5, 1'b1);
                step(10);
                check("A5 deliveries", rise_cnt, 1);
                check("A5 data", rise_data, 8'hA5);

                rx_ready = 1'b0;
                rise_cnt = 0;
                send_frame(8'h12, 1'b1);
                step(10);
                send_frame(8'h34, 1'b1);
                step(10);
                check("overrun data held", rx_data, 8'h12);
                check("overrun valid held", rx_valid, 1);
                check("overrun flag", overrun, 1);
                check("overrun deliveries", rise_cnt, 1);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
                step(1);
                check("accept clears valid", rx_valid, 0);
                check("accept clears overrun", overrun, 0);
                rx_ready = 1'b1;

                rise_cnt = 0;
                send_frame(8'h3C, 1'b1);
                send_frame(8'hC3, 1'b1);
                step(10);
                check("back-to-back deliveries", rise_cnt, 2);
                check("back-to-back last data", rise_data, 8'hC3);

                rise_cnt = 0;
                rx_in = 1'b0;
                step(16 + 64);
                reset = 1'b1;
                rx_in = 1'b1;
                step(3);
                reset = 1'b0;
                step(20);
                check("reset abort busy", busy, 0);
                check("reset abort deliveries", rise_cnt, 0);
                send_frame(8'h0F, 1'b1);
                step(10);
                check("0F deliveries", rise_cnt, 1);
                check("0F data", rx_data, 8'h0F);
            end
        join_any
        disable fork;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
